// File: rtl/mux_arb_nto1_pkg.sv
// Shared types and helpers for the N:1 arbitrating multiplexer.
package mux_pkg;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

    localparam int unsigned MAX_CHANNELS = 16;
    localparam int unsigned MAX_SEL_W    = $clog2(MAX_CHANNELS);

    // Index of the set bit in a one-hot (or zero) vector.
    function automatic logic [MAX_SEL_W-1:0] onehot_to_idx(input logic [MAX_CHANNELS-1:0] oh);
        logic [MAX_SEL_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
            if (oh[i]) idx = idx | MAX_SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_pick.sv
// Combinational search: first asserted request at or after ptr, wrapping modulo CHANNELS.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    winner,
    output logic                any
);

    logic [CHANNELS-1:0] onehot;
    logic                found;
    int unsigned         pos;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            pos = (32'(ptr) + i) % CHANNELS;
            if (!found && req[SEL_W'(pos)]) begin
                found               = 1'b1;
                onehot[SEL_W'(pos)] = 1'b1;
            end
        end
        winner = SEL_W'(onehot_to_idx(MAX_CHANNELS'(onehot)));
    end

    assign any = |req;

endmodule

// File: rtl/mux_arb_nto1.sv
// N-channel to 1 arbitrating multiplexer with a registered, handshaked output stage.
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter  int unsigned n        = 8,
    parameter  int unsigned CHANNELS = 4,
    parameter  arb_mode_t   MODE     = ARB_RR,
    localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CHANNELS*n-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    output logic [n-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      grant
);

    out_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] ptr_next;
    logic             any;
    logic             load;
    logic [n-1:0]     win_data;

    // Fixed priority is a round-robin search that always starts at channel 0.
    assign pick_ptr = (MODE == ARB_RR) ? ptr : '0;

    rr_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req    (in_valid),
        .ptr    (pick_ptr),
        .winner (winner),
        .any    (any)
    );

    assign out_valid = (state == FULL);
    assign load      = en && any && (!out_valid || out_ready);
    assign in_ready  = (load && !rst) ? (CHANNELS'(1) << winner) : '0;
    assign ptr_next  = (winner == SEL_W'(CHANNELS - 1)) ? '0 : winner + SEL_W'(1);

    // Compare-and-select so only the winning slice can reach the output register.
    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (SEL_W'(k) == winner) win_data = in_data[k*n +: n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            grant    <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state    <= FULL;
                        out_data <= win_data;
                        grant    <= winner;
                        if (MODE == ARB_RR) ptr <= ptr_next;
                    end
                end
                FULL: begin
                    if (load) begin
                        out_data <= win_data;
                        grant    <= winner;
                        if (MODE == ARB_RR) ptr <= ptr_next;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: a fixed-priority and a round-robin instance on shared stimulus.
module tb_mux_arb_nto1;
    import mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        out_ready = 1'b1;
    logic [3:0]  in_valid = 4'b0000;
    logic [7:0]  chan_data [4];
    logic [31:0] in_data;

    // Index 0 = fixed priority instance, index 1 = round-robin instance.
    logic [3:0]  rdy [2];
    logic [7:0]  dat [2];
    logic        vld [2];
    logic [1:0]  gnt [2];

    int checks = 0;
    int failures = 0;

    // Reference state per mode.
    int         m_valid [2];
    int         m_grant [2];
    int         m_ptr   [2];
    logic [7:0] m_data  [2];

    always #5 clk = ~clk;

    always_comb in_data = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};

    mux_arb_nto1 #(.n(8), .CHANNELS(4), .MODE(ARB_FIXED)) dut_fp (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[0]), .out_data(dat[0]), .out_valid(vld[0]),
        .out_ready(out_ready), .grant(gnt[0])
    );

    mux_arb_nto1 #(.n(8), .CHANNELS(4), .MODE(ARB_RR)) dut_rr (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy[1]), .out_data(dat[1]), .out_valid(vld[1]),
        .out_ready(out_ready), .grant(gnt[1])
    );

    function automatic int pick(int md);
        int start = (md == 1) ? m_ptr[md] : 0;
        for (int j = 0; j < 4; j++) begin
            if (in_valid[(start + j) % 4]) return (start + j) % 4;
        end
        return -1;
    endfunction

    function automatic bit m_load(int md);
        return en && (pick(md) >= 0) && (m_valid[md] == 0 || out_ready);
    endfunction

    function automatic logic [3:0] m_ready(int md);
        if (rst || !m_load(md)) return 4'b0000;
        return 4'b0001 << pick(md);
    endfunction

    task automatic model_reset();
        for (int md = 0; md < 2; md++) begin
            m_valid[md] = 0; m_grant[md] = 0; m_ptr[md] = 0; m_data[md] = 8'h00;
        end
    endtask

    // Advance one clock edge, updating the reference from the pre-edge inputs.
    task automatic cycle();
        bit ld [2];
        int w  [2];
        for (int md = 0; md < 2; md++) begin
            ld[md] = m_load(md);
            w[md]  = pick(md);
        end
        @(posedge clk);
        if (!rst) begin
            for (int md = 0; md < 2; md++) begin
                if (ld[md]) begin
                    m_valid[md] = 1;
                    m_data[md]  = chan_data[w[md]];
                    m_grant[md] = w[md];
                    if (md == 1) m_ptr[md] = (w[md] + 1) % 4;
                end else if (m_valid[md] != 0 && out_ready) begin
                    m_valid[md] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        for (int k = 0; k < 4; k++) chan_data[k] = 8'(8'h10 + k);
        model_reset();
        @(posedge clk);
        #1;
        for (int md = 0; md < 2; md++) begin
            checks++;
            if (vld[md] !== 1'b0 || dat[md] !== 8'h00 || gnt[md] !== 2'd0 || rdy[md] !== 4'b0000) begin
                failures++;
                $display("FAIL reset_state md=%0d got v=%b d=%h g=%0d r=%b exp all zero", md, vld[md], dat[md], gnt[md], rdy[md]);
            end
        end
        rst = 1'b0;
        #1;
        cycle();
        cycle();
        checks++;
        if (vld[1] !== 1'b1 || gnt[1] !== 2'd1) begin
            failures++;
            $display("FAIL pre_reset_load got v=%b g=%0d exp v=1 g=1", vld[1], gnt[1]);
        end
        out_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        for (int md = 0; md < 2; md++) begin
            checks++;
            if (vld[md] !== 1'b0 || dat[md] !== 8'h00 || gnt[md] !== 2'd0 || rdy[md] !== 4'b0000) begin
                failures++;
                $display("FAIL midrun_reset md=%0d got v=%b d=%h g=%0d r=%b exp all zero", md, vld[md], dat[md], gnt[md], rdy[md]);
            end
        end
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int md = 0; md < 2; md++) begin
            checks++;
            if (rdy[md] !== 4'b0001) begin
                failures++;
                $display("FAIL post_reset_ready md=%0d got %b exp 0001", md, rdy[md]);
            end
        end
        cycle();
        for (int md = 0; md < 2; md++) begin
            checks++;
            if (gnt[md] !== 2'd0 || dat[md] !== 8'h10 || vld[md] !== 1'b1) begin
                failures++;
                $display("FAIL post_reset_grant md=%0d got g=%0d d=%h v=%b exp g=0 d=10 v=1", md, gnt[md], dat[md], vld[md]);
            end
        end
    endtask

    task automatic test_rr_sequence();
        do_reset();
        for (int k = 0; k < 4; k++) chan_data[k] = 8'(8'hA0 + k);
        in_valid = 4'b1111; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rdy[1] !== (4'b0001 << (i % 4))) begin
                failures++;
                $display("FAIL rr_ready step=%0d got %b exp %b", i, rdy[1], 4'b0001 << (i % 4));
            end
            cycle();
            checks++;
            if (vld[1] !== 1'b1 || dat[1] !== 8'(8'hA0 + i % 4) || gnt[1] !== 2'(i % 4)) begin
                failures++;
                $display("FAIL rr_seq step=%0d got d=%h g=%0d exp d=%h g=%0d", i, dat[1], gnt[1], 8'(8'hA0 + i % 4), i % 4);
            end
            checks++;
            if (dat[0] !== 8'hA0 || gnt[0] !== 2'd0) begin
                failures++;
                $display("FAIL fp_all_valid step=%0d got d=%h g=%0d exp d=a0 g=0", i, dat[0], gnt[0]);
            end
        end
    endtask

    task automatic test_fixed();
        in_valid = 4'b1010; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) chan_data[k] = 8'($urandom);
            #1;
            checks++;
            if (rdy[0] !== 4'b0010) begin
                failures++;
                $display("FAIL fp_ready step=%0d got %b exp 0010", i, rdy[0]);
            end
            cycle();
            checks++;
            if (gnt[0] !== 2'd1 || dat[0] !== chan_data[1] || vld[0] !== 1'b1) begin
                failures++;
                $display("FAIL fp_grant step=%0d got g=%0d d=%h exp g=1 d=%h", i, gnt[0], dat[0], chan_data[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        chan_data[2] = 8'h5C;
        in_valid = 4'b0100; out_ready = 1'b1; en = 1'b1;
        cycle();
        out_ready = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            chan_data[2] = 8'($urandom);
            #1;
            checks++;
            if (rdy[1] !== 4'b0000) begin
                failures++;
                $display("FAIL bp_ready step=%0d got %b exp 0000", i, rdy[1]);
            end
            cycle();
            checks++;
            if (vld[1] !== 1'b1 || dat[1] !== 8'h5C || gnt[1] !== 2'd2) begin
                failures++;
                $display("FAIL bp_hold step=%0d got v=%b d=%h g=%0d exp v=1 d=5c g=2", i, vld[1], dat[1], gnt[1]);
            end
        end
        out_ready = 1'b1;
        in_valid = 4'b0001;
        chan_data[0] = 8'h3E;
        #1;
        checks++;
        if (rdy[1] !== 4'b0001) begin
            failures++;
            $display("FAIL bp_drain_ready got %b exp 0001", rdy[1]);
        end
        cycle();
        checks++;
        if (vld[1] !== 1'b1 || dat[1] !== 8'h3E || gnt[1] !== 2'd0) begin
            failures++;
            $display("FAIL bp_drain_load got v=%b d=%h g=%0d exp v=1 d=3e g=0", vld[1], dat[1], gnt[1]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1; en = 1'b1;
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b0101;
        #1;
        checks++;
        if (rdy[1] !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_ready got %b exp 0001", rdy[1]);
        end
        cycle();
        checks++;
        if (gnt[1] !== 2'd0) begin
            failures++;
            $display("FAIL wrap_grant got %0d exp 0", gnt[1]);
        end
        cycle();
        checks++;
        if (gnt[1] !== 2'd2) begin
            failures++;
            $display("FAIL skip_grant got %0d exp 2", gnt[1]);
        end
    endtask

    // Entered with the rr output FULL holding a channel-2 transfer, ptr=3.
    task automatic test_enable();
        en = 1'b0; out_ready = 1'b0; in_valid = 4'b1111;
        #1;
        for (int md = 0; md < 2; md++) begin
            checks++;
            if (rdy[md] !== 4'b0000) begin
                failures++;
                $display("FAIL en_low_ready md=%0d got %b exp 0000", md, rdy[md]);
            end
        end
        cycle();
        checks++;
        if (vld[1] !== 1'b1 || gnt[1] !== 2'd2) begin
            failures++;
            $display("FAIL en_low_hold got v=%b g=%0d exp v=1 g=2", vld[1], gnt[1]);
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (vld[1] !== 1'b0 || vld[0] !== 1'b0) begin
            failures++;
            $display("FAIL en_low_drain got v=%b/%b exp 0/0", vld[0], vld[1]);
        end
        en = 1'b1;
        #1;
        checks++;
        if (rdy[1] !== 4'b1000) begin
            failures++;
            $display("FAIL en_resume_ready got %b exp 1000", rdy[1]);
        end
        cycle();
        checks++;
        if (gnt[1] !== 2'd3 || vld[1] !== 1'b1) begin
            failures++;
            $display("FAIL en_resume_grant got g=%0d v=%b exp g=3 v=1", gnt[1], vld[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 4'($urandom);
            for (int k = 0; k < 4; k++) chan_data[k] = 8'($urandom);
            #1;
            for (int md = 0; md < 2; md++) begin
                checks++;
                if (rdy[md] !== m_ready(md)) begin
                    failures++;
                    $display("FAIL rand_ready i=%0d md=%0d got %b exp %b", i, md, rdy[md], m_ready(md));
                end
            end
            cycle();
            for (int md = 0; md < 2; md++) begin
                checks++;
                if (vld[md] !== (m_valid[md] != 0) || dat[md] !== m_data[md] || gnt[md] !== 2'(m_grant[md])) begin
                    failures++;
                    $display("FAIL rand_out i=%0d md=%0d got v=%b d=%h g=%0d exp v=%0d d=%h g=%0d",
                             i, md, vld[md], dat[md], gnt[md], m_valid[md], m_data[md], m_grant[md]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_sequence();
        test_fixed();
        test_backpressure();
        test_wrap();
        test_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_nto1.md
Name: mux_arb_nto1

Overview:
Parametrised N-channel to 1 arbitrating multiplexer with a registered output and valid/ready handshakes on every port. It generalises the catalog 4:1 mux in data width and channel count. It replaces the external select with an internal fixed-priority or round-robin arbiter. It sits in front of shared resources (register-file write port, memory request bus) where several producers compete for one consumer.

Parameters:
- n, 8, data width per channel in bits.
- CHANNELS, 4, number of input channels; legal range 2..16.
- MODE, 1, arbitration mode; 0 = fixed priority (channel 0 highest), 1 = round robin.
- SEL_W, $clog2(CHANNELS), width of the grant index. Derived; not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; when low, no new transfer is accepted and the output register holds.
- in_data  input  CHANNELS*n  packed channel data; channel k occupies bits [k*n +: n].
- in_valid  input  CHANNELS  per-channel request valid.
- in_ready  output  CHANNELS  per-channel accept. One-hot or zero, combinational.
- out_data  output  n  registered selected data.
- out_valid  output  1  out_data holds a transfer.
- out_ready  input  1  downstream accept.
- grant  output  SEL_W  registered index of the channel whose data is in out_data.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, grant=0, round-robin pointer ptr=0. in_ready is all-zero while rst=1.
- Output register is a 2-state FSM:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = en && |in_valid && (!out_valid || out_ready).
- Winner selection:
  - MODE 0: lowest-index asserted in_valid.
  - MODE 1: first asserted in_valid at or after ptr, searching upward with wrap-around modulo CHANNELS.
- in_ready[winner] = load. All other in_ready bits are 0. in_ready never depends on in_valid of other channels beyond winner selection.
- On a clock edge with load=1: out_data <= winner data, grant <= winner, out_valid <= 1. In MODE 1, ptr <= (winner+1) mod CHANNELS, with the wrap from CHANNELS-1 to 0.
- On a clock edge with load=0 and out_valid && out_ready: out_valid <= 0. out_data and grant hold their last values.
- Otherwise all state holds. In particular, out_valid=1 with out_ready=0 holds data and grant stable.
- ptr advances only on a successful load, never on idle cycles.
- Latency: one cycle from in_valid&&in_ready to out_valid.
- Throughput: one transfer per cycle when out_ready is held high (simultaneous drain and load in FULL).
- en=0: load is forced to 0. A transfer already in FULL still drains on out_ready, and the FSM returns to EMPTY.
- All CHANNELS valid, MODE 1: grants cycle 0,1,...,CHANNELS-1,0. No channel waits more than CHANNELS-1 grants.
- Single requester: granted every cycle, regardless of ptr.
- Reset asserted mid-transfer: held data is discarded and ptr returns to 0. No in_ready is asserted during reset.
- No X propagation: an unselected channel's data never reaches out_data.

Decomposition:
- Package mux_pkg:
  - typedef enum arb_mode_t {ARB_FIXED=0, ARB_RR=1}.
  - Constant MAX_CHANNELS=16.
  - Function onehot_to_idx.
- Sub-module rr_pick: purely combinational. Inputs are the request vector and ptr. Outputs are the winner index and an any-flag. MODE 0 instantiates it with ptr tied to 0.
- The top level holds the FSM, the ptr register and the packed-data slice mux.

Test Plan:
- Reset: drive rst=1 mid-run with out_valid=1 -> immediately out_valid=0, out_data=0, grant=0, in_ready=0; after release, the first grant with all valid is channel 0.
- Round robin, CHANNELS=4, n=8: all valid, data 8'hA0..8'hA3, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0, one per cycle; grant 0,1,2,3,0.
- Fixed priority, MODE=0: in_valid=4'b1010 -> only channel 1 is granted every cycle; channel 3 is never granted while channel 1 is valid.
- Backpressure: out_ready=0 for 3 cycles after a load of 8'h5C from channel 2 -> out_data=5C, grant=2 stable; in_ready=0. Then out_ready=1 with in_valid=4'b0001 -> the next load is channel 0 in the same cycle as the drain.
- Wrap and skip, MODE=1: ptr=3 after a channel-2 grant, in_valid=4'b0101 -> the winner is channel 0 (wrap), then ptr=1 and the next winner is channel 2.
- Enable: en=0 with all valid -> no in_ready and no new out_valid; a pending output still drains on out_ready; raising en resumes from the held ptr.
